rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Read-port arbiter and sequencer for the single-ported, combinational instruction ROM. It shares one ROM read port between the instruction-fetch requester (port I) and the data-load requester (port D). It converts byte addresses to ROM word indices and registers each response. It holds off all grants for a fixed boot window after reset.

## Interface
Parameters:
- DATA_SIZE, 32, ROM word width
- SELEC_SIZE, 32, byte-address width and ROM index width
- BOOT_CYCLES, 4, cycles after reset release during which no grant is issued (0 allowed)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  port I read request; held with i_addr until i_gnt
- i_addr  in  SELEC_SIZE  port I byte address
- i_gnt  out  1  port I request accepted this cycle (combinational)
- i_rvalid  out  1  port I response valid, one-cycle pulse
- i_rdata  out  DATA_SIZE  port I read data, held until next port I response
- i_rerr  out  1  port I misaligned-address flag, qualified by i_rvalid
- d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_rerr: same as above for port D
- rom_address  out  SELEC_SIZE  word index to ROM
- rom_out  in  DATA_SIZE  ROM data for rom_address (combinational)
- busy  out  1  high while in BOOT state

## Operation
- States: BOOT, RUN. rst forces BOOT with boot counter 0. If BOOT_CYCLES == 0, rst forces RUN instead.
- BOOT: counter increments each clk. The FSM enters RUN on the edge where the counter reaches BOOT_CYCLES-1. No gnt is issued in BOOT. busy=1.
- RUN: at most one gnt per cycle. Requests are never dropped; a requester keeps req high until granted.
- Arbitration: round-robin with a 1-bit last-grant pointer. Reset value of the pointer is "D", so I wins the first tie.
  - Only one req high: that port is granted and the pointer is set to it.
  - Both high: the port not granted last is granted, and the pointer toggles.
- Grant cycle: rom_address = {2'b00, addr[SELEC_SIZE-1:2]} of the granted port. When no grant, rom_address holds its previously driven value; reset value 0.
- Response, captured at the edge ending the grant cycle:
  - Aligned (addr[1:0]==0): rdata <= rom_out, rerr <= 0.
  - Misaligned: rdata <= 0, rerr <= 1.
  - rvalid <= 1 for exactly the following cycle.
- rdata and rerr of a port hold their values until that port's next response.
- rst mid-operation: all state clears immediately. The in-flight response is lost; no rvalid is issued for it. Requesters must re-issue.
- Reset values: all gnt and rvalid outputs 0; i_rdata and d_rdata 0; i_rerr and d_rerr 0; rom_address 0; busy 1 (0 if BOOT_CYCLES==0).

## Timing
- i_gnt and d_gnt are combinational from req, state and pointer. They do not depend on addr.
- Latency is one cycle: a grant in cycle N gives rvalid high in cycle N+1.
- Throughput is one response per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Under continuous contention the ports alternate I, D, I, D. Worst-case wait is one cycle.
- First possible grant is in cycle BOOT_CYCLES, counting the first rising edge after rst release as the end of cycle 0. The ROM must not be addressed earlier.
- busy falls in the same cycle the first grant becomes possible.

## Test plan
- Boot window: BOOT_CYCLES=4, i_req held high from rst release -> i_gnt=0 and busy=1 for cycles 0-3; i_gnt=1 and busy=0 in cycle 4; i_rvalid in cycle 5.
- Single port, word conversion: mem[0x10]=0xDEADBEEF, i_addr=0x40 -> rom_address=0x10 in the grant cycle; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, i_rerr=0.
- Contention: both req high for 4 cycles after boot -> grants I, D, I, D; each rvalid one cycle after its grant; i_rdata holds while D is served.
- Misaligned: d_addr=0x42 -> d_gnt=1; next cycle d_rvalid=1, d_rerr=1, d_rdata=0. A following aligned d_addr=0x44 returns mem[0x11] with d_rerr=0.
- Reset mid-operation: rst asserted in the cycle after a grant, before rvalid is sampled -> rvalid, gnt and rdata go to 0 immediately; busy=1; a new boot window of BOOT_CYCLES runs before the next grant.
- BOOT_CYCLES=0: req high at rst release -> grant in cycle 0; busy never asserts.

Source files
------------

// File: rtl/rom_arbiter.sv
// Shares one combinational ROM read port between instruction fetch (I) and data load (D).
// Round-robin grant, byte-to-word address conversion, registered responses, post-reset boot hold-off.
module rom_arbiter #(
    parameter int DATA_SIZE   = 32,
    parameter int SELEC_SIZE  = 32,
    parameter int BOOT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [SELEC_SIZE-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_SIZE-1:0]  i_rdata,
    output logic                  i_rerr,
    input  logic                  d_req,
    input  logic [SELEC_SIZE-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_SIZE-1:0]  d_rdata,
    output logic                  d_rerr,
    output logic [SELEC_SIZE-1:0] rom_address,
    input  logic [DATA_SIZE-1:0]  rom_out,
    output logic                  busy
);

    localparam logic ST_BOOT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic RST_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;
    localparam int CNT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int LAST_INT = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = LAST_INT[CNT_W-1:0];

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_d_q, last_d_d;
    logic             run;

    logic [SELEC_SIZE-1:0] rom_addr_q, rom_addr_d;
    logic                  i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic                  i_rerr_q, i_rerr_d, d_rerr_q, d_rerr_d;
    logic [DATA_SIZE-1:0]  i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_BOOT) begin
            if (cnt_q == LAST_CNT) state_d = ST_RUN;
            else                   cnt_d   = cnt_q + 1'b1;
        end
    end

    // Grants are gated by rst so nothing is granted while reset is held, even in RUN.
    always_comb begin
        run   = (state_q == ST_RUN) && !rst;
        busy  = (state_q == ST_BOOT);
        i_gnt = run && i_req && (!d_req || last_d_q);
        d_gnt = run && d_req && (!i_req || !last_d_q);
    end

    always_comb begin
        last_d_d   = last_d_q;
        rom_addr_d = rom_addr_q;
        i_rvalid_d = i_gnt;
        d_rvalid_d = d_gnt;
        i_rdata_d  = i_rdata_q;
        i_rerr_d   = i_rerr_q;
        d_rdata_d  = d_rdata_q;
        d_rerr_d   = d_rerr_q;
        if (i_gnt) begin
            last_d_d   = 1'b0;
            rom_addr_d = {2'b00, i_addr[SELEC_SIZE-1:2]};
            i_rerr_d   = (i_addr[1:0] != 2'b00);
            i_rdata_d  = (i_addr[1:0] == 2'b00) ? rom_out : '0;
        end else if (d_gnt) begin
            last_d_d   = 1'b1;
            rom_addr_d = {2'b00, d_addr[SELEC_SIZE-1:2]};
            d_rerr_d   = (d_addr[1:0] != 2'b00);
            d_rdata_d  = (d_addr[1:0] == 2'b00) ? rom_out : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q   <= 1'b1;
            rom_addr_q <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            i_rerr_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_rerr_q   <= 1'b0;
        end else begin
            last_d_q   <= last_d_d;
            rom_addr_q <= rom_addr_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_rerr_q   <= i_rerr_d;
            d_rdata_q  <= d_rdata_d;
            d_rerr_q   <= d_rerr_d;
        end
    end

    assign rom_address = rom_addr_d;
    assign i_rvalid    = i_rvalid_q;
    assign i_rdata     = i_rdata_q;
    assign i_rerr      = i_rerr_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_rdata     = d_rdata_q;
    assign d_rerr      = d_rerr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: boot window, word conversion, contention, misalignment, reset, zero boot.
module tb_rom_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BOOT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:255];

    logic          i_req = 1'b0, d_req = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic          i_gnt, d_gnt, i_rvalid, d_rvalid, i_rerr, d_rerr, busy;
    logic [DW-1:0] i_rdata, d_rdata, rom_out;
    logic [AW-1:0] rom_address;

    logic          i2_req = 1'b0;
    logic [AW-1:0] i2_addr = '0;
    logic          d2_req = 1'b0;
    logic [AW-1:0] d2_addr = '0;
    logic          i2_gnt, d2_gnt, i2_rvalid, d2_rvalid, i2_rerr, d2_rerr, busy2;
    logic [DW-1:0] i2_rdata, d2_rdata, rom_out2;
    logic [AW-1:0] rom_address2;

    assign rom_out  = mem[rom_address[7:0]];
    assign rom_out2 = mem[rom_address2[7:0]];

    rom_arbiter #(.DATA_SIZE(DW), .SELEC_SIZE(AW), .BOOT_CYCLES(BOOT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_rerr(i_rerr),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_rerr(d_rerr),
        .rom_address(rom_address), .rom_out(rom_out), .busy(busy)
    );

    rom_arbiter #(.DATA_SIZE(DW), .SELEC_SIZE(AW), .BOOT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(i2_req), .i_addr(i2_addr), .i_gnt(i2_gnt), .i_rvalid(i2_rvalid),
        .i_rdata(i2_rdata), .i_rerr(i2_rerr),
        .d_req(d2_req), .d_addr(d2_addr), .d_gnt(d2_gnt), .d_rvalid(d2_rvalid),
        .d_rdata(d2_rdata), .d_rerr(d2_rerr),
        .rom_address(rom_address2), .rom_out(rom_out2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Advance to the start of the next cycle (just after the rising edge).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset for one edge, release it, and leave the bench at the start of cycle 0.
    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h40;
        i2_req = 1'b1; i2_addr = 32'h40;
        step(); step();
        @(negedge clk);
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {i_gnt, d_gnt, i_rvalid, d_rvalid});
        end
        n_cmp++;
        if ({i_rdata, d_rdata, i_rerr, d_rerr} !== '0) begin
            n_bad++; $display("FAIL reset_data: got %h %h %b %b want 0", i_rdata, d_rdata, i_rerr, d_rerr);
        end
        n_cmp++;
        if (rom_address !== 32'h0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL reset_addr_busy: got %h %b want 0 1", rom_address, busy);
        end
        n_cmp++;
        if (busy2 !== 1'b0 || i2_gnt !== 1'b0) begin
            n_bad++; $display("FAIL reset_boot0: busy2 %b gnt2 %b want 0 0", busy2, i2_gnt);
        end
    endtask

    task automatic test_boot();
        step();
        rst = 1'b0;
        for (int c = 0; c < BOOT; c++) begin
            @(negedge clk);
            n_cmp++;
            if (i_gnt !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL boot_hold c%0d: gnt %b busy %b want 0 1", c, i_gnt, busy);
            end
            if (c == 0) begin
                n_cmp++;
                if (i2_gnt !== 1'b1 || busy2 !== 1'b0 || rom_address2 !== 32'h10) begin
                    n_bad++; $display("FAIL boot0_grant: gnt %b busy %b addr %h want 1 0 10", i2_gnt, busy2, rom_address2);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if (i2_rvalid !== 1'b1 || i2_rdata !== 32'hDEADBEEF || i2_rerr !== 1'b0) begin
                    n_bad++; $display("FAIL boot0_resp: got %b %h %b want 1 deadbeef 0", i2_rvalid, i2_rdata, i2_rerr);
                end
            end
            step();
            if (c == 0) i2_req = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1 || busy !== 1'b0 || rom_address !== 32'h10) begin
            n_bad++; $display("FAIL boot_first_grant: gnt %b busy %b addr %h want 1 0 10", i_gnt, busy, rom_address);
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF || i_rerr !== 1'b0) begin
            n_bad++; $display("FAIL word_read: got %b %h %b want 1 deadbeef 0", i_rvalid, i_rdata, i_rerr);
        end
        n_cmp++;
        if (rom_address !== 32'h10 || i_gnt !== 1'b0) begin
            n_bad++; $display("FAIL addr_hold: got %h gnt %b want 10 0", rom_address, i_gnt);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rvalid_pulse: got %b %h want 0 deadbeef", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_i;
        logic [AW-1:0] exp_a [0:3];
        exp_i = 4'b0101;
        exp_a[0] = 32'h10; exp_a[1] = 32'h12; exp_a[2] = 32'h11; exp_a[3] = 32'h12;
        pulse_reset();
        repeat (BOOT) step();
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h48;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (i_gnt !== exp_i[c] || d_gnt !== !exp_i[c] || rom_address !== exp_a[c]) begin
                n_bad++; $display("FAIL contend_gnt c%0d: i %b d %b addr %h want %b %b %h",
                                  c, i_gnt, d_gnt, rom_address, exp_i[c], !exp_i[c], exp_a[c]);
            end
            if (c > 0) begin
                n_cmp++;
                if (i_rvalid !== exp_i[c-1] || d_rvalid !== !exp_i[c-1]) begin
                    n_bad++; $display("FAIL contend_rvalid c%0d: i %b d %b want %b %b",
                                      c, i_rvalid, d_rvalid, exp_i[c-1], !exp_i[c-1]);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (i_rdata !== 32'hDEADBEEF || d_rdata !== 32'h12345678) begin
                    n_bad++; $display("FAIL contend_hold: i %h d %h want deadbeef 12345678", i_rdata, d_rdata);
                end
            end
            step();
            if (c == 0) i_addr = 32'h44;
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || i_rdata !== 32'hCAFEF00D || d_rdata !== 32'h12345678) begin
            n_bad++; $display("FAIL contend_tail: dv %b iv %b i %h d %h want 1 0 cafef00d 12345678",
                              d_rvalid, i_rvalid, i_rdata, d_rdata);
        end
        step();
    endtask

    task automatic test_misaligned();
        d_req = 1'b1; d_addr = 32'h48;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            n_bad++; $display("FAIL single_d_gnt: d %b i %b want 1 0", d_gnt, i_gnt);
        end
        step();
        d_addr = 32'h42;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'h12345678 || rom_address !== 32'h10) begin
            n_bad++; $display("FAIL mis_grant: gnt %b rv %b data %h addr %h want 1 1 12345678 10",
                              d_gnt, d_rvalid, d_rdata, rom_address);
        end
        step();
        d_addr = 32'h44;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rerr !== 1'b1 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL mis_resp: rv %b err %b data %h want 1 1 0", d_rvalid, d_rerr, d_rdata);
        end
        n_cmp++;
        if (d_gnt !== 1'b1 || rom_address !== 32'h11) begin
            n_bad++; $display("FAIL realign_grant: gnt %b addr %h want 1 11", d_gnt, rom_address);
        end
        step();
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rerr !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL realign_resp: rv %b err %b data %h want 1 0 cafef00d", d_rvalid, d_rerr, d_rdata);
        end
        n_cmp++;
        if (i_rerr !== 1'b0 || i_rdata !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL i_untouched: err %b data %h want 0 cafef00d", i_rerr, i_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_addr = 32'h40;
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre_gnt: got %b want 1", i_gnt);
        end
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h0 || i_gnt !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset: rv %b data %h gnt %b busy %b want 0 0 0 1", i_rvalid, i_rdata, i_gnt, busy);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < BOOT; c++) begin
            @(negedge clk);
            n_cmp++;
            if (i_gnt !== 1'b0 || i_rvalid !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL mid_reboot c%0d: gnt %b rv %b busy %b want 0 0 1", c, i_gnt, i_rvalid, busy);
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_regrant: gnt %b busy %b want 1 0", i_gnt, busy);
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d2_gnt, d2_rvalid, d2_rerr, d2_rdata, i2_rerr} !== '0) begin
            n_bad++; $display("FAIL boot0_idle_d: got %b %b %b %h %b want 0", d2_gnt, d2_rvalid, d2_rerr, d2_rdata, i2_rerr);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h0100_0000 + k;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h11] = 32'hCAFEF00D;
        mem[8'h12] = 32'h12345678;
        test_reset();
        test_boot();
        test_contention();
        test_misaligned();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
